// File: rtl/seq_multiplier_pkg.sv
// Shared types and constants for the iterative multiplier.
package mul_pkg;

  // Multiply flavour requested by the control unit.
  typedef enum logic [1:0] {
    OP_MUL   = 2'b00,
    OP_SMULH = 2'b01,
    OP_UMULH = 2'b10,
    OP_RSVD  = 2'b11
  } op_t;

  // Multiplier sequencing states.
  typedef enum logic [1:0] {
    IDLE = 2'b00,
    BUSY = 2'b01,
    FIX  = 2'b10,
    DONE = 2'b11
  } state_t;

  // Zero register; writes to it are suppressed.
  localparam logic [4:0] XZR = 5'd31;

endpackage

// File: rtl/seq_multiplier_if.sv
// Request/writeback bundle between the control unit and the multiplier.
interface seq_multiplier_if
  import mul_pkg::*;
#(
  parameter int N = 64
);
  logic         start;
  op_t          op;
  logic [N-1:0] a;
  logic [N-1:0] b;
  logic [4:0]   dest;
  logic         flush;
  logic         ready;
  logic         done;
  logic         we3;
  logic [4:0]   wa3;
  logic [N-1:0] wd3;

  modport master (
    output start, op, a, b, dest, flush,
    input  ready, done, we3, wa3, wd3
  );

  modport slave (
    input  start, op, a, b, dest, flush,
    output ready, done, we3, wa3, wd3
  );
endinterface

// File: rtl/seq_multiplier_abs_neg.sv
// Conditional two's-complement negation of a W-bit value.
module abs_neg #(
  parameter int W = 64
) (
  input  logic         neg,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout
);

  assign dout = neg ? (~din + W'(1)) : din;

endmodule

// File: rtl/seq_multiplier.sv
// Iterative shift-add multiplier for MUL / SMULH / UMULH with register-file
// writeback. One operation in flight; ready is low while busy.
module seq_multiplier
  import mul_pkg::*;
#(
  parameter int N  = 64,
  parameter int CW = 7
) (
  input  logic              clk,
  input  logic              reset,
  seq_multiplier_if.slave   bus
);

  state_t           state;
  logic [N-1:0]     mcand;
  logic [N-1:0]     mplier;
  logic [2*N-1:0]   acc;
  logic             sign;
  op_t              op_q;
  logic [4:0]       dest_q;
  logic [CW-1:0]    cnt;

  logic             ready_q;
  logic             done_q;
  logic             we3_q;
  logic [4:0]       wa3_q;
  logic [N-1:0]     wd3_q;

  logic             is_smulh;
  logic [N-1:0]     a_mag;
  logic [N-1:0]     b_mag;
  logic [2*N-1:0]   prod;
  logic [N-1:0]     addend;
  logic [N:0]       sum;
  logic [2*N-1:0]   acc_step;

  // Only SMULH works on magnitudes; MUL low bits are sign-independent.
  assign is_smulh = (bus.op == OP_SMULH);

  abs_neg #(.W(N)) u_abs_a (
    .neg  (is_smulh & bus.a[N-1]),
    .din  (bus.a),
    .dout (a_mag)
  );

  abs_neg #(.W(N)) u_abs_b (
    .neg  (is_smulh & bus.b[N-1]),
    .din  (bus.b),
    .dout (b_mag)
  );

  abs_neg #(.W(2*N)) u_fix (
    .neg  (sign),
    .din  (acc),
    .dout (prod)
  );

  // One shift-add step: add into the upper half keeping the carry, then
  // shift the whole accumulator right by one.
  always_comb begin
    addend   = mplier[0] ? mcand : '0;
    sum      = {1'b0, acc[2*N-1:N]} + {1'b0, addend};
    acc_step = {sum, acc[N-1:1]};
  end

  // Sequencer, datapath registers and registered writeback outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= IDLE;
      mcand   <= '0;
      mplier  <= '0;
      acc     <= '0;
      sign    <= 1'b0;
      op_q    <= OP_MUL;
      dest_q  <= '0;
      cnt     <= '0;
      ready_q <= 1'b1;
      done_q  <= 1'b0;
      we3_q   <= 1'b0;
      wa3_q   <= '0;
      wd3_q   <= '0;
    end else if (bus.flush) begin
      state   <= IDLE;
      ready_q <= 1'b1;
      done_q  <= 1'b0;
      we3_q   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.start) begin
            mcand   <= a_mag;
            mplier  <= b_mag;
            sign    <= is_smulh & (bus.a[N-1] ^ bus.b[N-1]);
            op_q    <= bus.op;
            dest_q  <= bus.dest;
            acc     <= '0;
            cnt     <= '0;
            ready_q <= 1'b0;
            state   <= BUSY;
          end
        end
        BUSY: begin
          acc    <= acc_step;
          mplier <= mplier >> 1;
          cnt    <= cnt + CW'(1);
          if (cnt == CW'(N - 1)) begin
            state <= FIX;
          end
        end
        FIX: begin
          if (op_q == OP_SMULH || op_q == OP_UMULH) begin
            wd3_q <= prod[2*N-1:N];
          end else begin
            wd3_q <= prod[N-1:0];
          end
          wa3_q  <= dest_q;
          done_q <= 1'b1;
          we3_q  <= (dest_q != XZR);
          state  <= DONE;
        end
        DONE: begin
          done_q  <= 1'b0;
          we3_q   <= 1'b0;
          ready_q <= 1'b1;
          state   <= IDLE;
        end
        default: begin
          state   <= IDLE;
          ready_q <= 1'b1;
          done_q  <= 1'b0;
          we3_q   <= 1'b0;
        end
      endcase
    end
  end

  assign bus.ready = ready_q;
  assign bus.done  = done_q;
  assign bus.we3   = we3_q;
  assign bus.wa3   = wa3_q;
  assign bus.wd3   = wd3_q;

endmodule

// File: tb/tb_seq_multiplier.sv
// Scoreboard bench for seq_multiplier: stimulus pushes expected writebacks,
// a negedge monitor pops and compares on every done strobe.
module tb_seq_multiplier;
  import mul_pkg::*;

  localparam int N = 64;

  typedef struct {
    logic [4:0]   wa;
    logic [N-1:0] wd;
    logic         we;
    int unsigned  cyc;
  } exp_t;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  seq_multiplier_if #(.N(N)) bus();

  seq_multiplier #(.N(N), .CW(7)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  exp_t        sbq[$];
  int          total = 0;
  int          bad = 0;
  int unsigned cyc = 0;
  int          done_cnt = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [N-1:0] act, input logic [N-1:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  // Monitor: every done strobe must match the head of the scoreboard.
  always @(negedge clk) begin : mon
    exp_t e;
    if (reset) begin
      if (bus.we3 && !bus.done) begin
        total++;
        bad++;
        $display("FAIL we3_without_done actual=1 required=0");
      end
      if (bus.done) begin
        done_cnt++;
        if (sbq.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_done actual=1 required=0 at cyc %0d", cyc);
        end else begin
          e = sbq.pop_front();
          chk("wd3", bus.wd3, e.wd);
          chk("wa3", N'(bus.wa3), N'(e.wa));
          chk("we3", N'(bus.we3), N'(e.we));
          chk("latency", N'(cyc), N'(e.cyc));
        end
      end
    end
  end

  task automatic wait_ready();
    int n = 0;
    while (!bus.ready && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (!bus.ready) begin
      total++;
      bad++;
      $display("FAIL ready_timeout actual=0 required=1");
    end
  endtask

  task automatic issue(input op_t op, input logic [N-1:0] a, input logic [N-1:0] b,
                       input logic [4:0] dest, input logic push, input logic [N-1:0] wd);
    exp_t e;
    wait_ready();
    @(negedge clk);
    bus.start = 1'b1;
    bus.op    = op;
    bus.a     = a;
    bus.b     = b;
    bus.dest  = dest;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    bus.a     = {$urandom, $urandom};
    bus.b     = {$urandom, $urandom};
    bus.dest  = 5'($urandom);
    chk("ready_drop", N'(bus.ready), N'(0));
    if (push) begin
      e.wa  = dest;
      e.wd  = wd;
      e.we  = (dest != 5'd31);
      e.cyc = cyc + N + 1;
      sbq.push_back(e);
    end
  endtask

  task automatic drain();
    int n = 0;
    while (sbq.size() != 0 && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (sbq.size() != 0) begin
      total++;
      bad++;
      $display("FAIL drain_timeout pending=%0d required=0", sbq.size());
      sbq.delete();
    end
  endtask

  localparam logic [N-1:0] ONES = '1;
  localparam logic [N-1:0] MSB  = {1'b1, {(N-1){1'b0}}};

  initial begin
    int d0;
    bus.start = 1'b0;
    bus.flush = 1'b0;
    bus.op    = OP_MUL;
    bus.a     = '0;
    bus.b     = '0;
    bus.dest  = '0;

    repeat (2) @(negedge clk);
    chk("rst_ready", N'(bus.ready), N'(1));
    chk("rst_done", N'(bus.done), N'(0));
    chk("rst_we3", N'(bus.we3), N'(0));
    chk("rst_wa3", N'(bus.wa3), N'(0));
    chk("rst_wd3", bus.wd3, '0);
    reset = 1'b1;

    issue(OP_MUL, 64'd3, 64'd5, 5'd2, 1'b1, 64'd15);
    drain();
    issue(OP_UMULH, ONES, ONES, 5'd3, 1'b1, 64'hFFFF_FFFF_FFFF_FFFE);
    issue(OP_MUL, ONES, ONES, 5'd4, 1'b1, 64'd1);
    issue(OP_SMULH, ONES, 64'd5, 5'd5, 1'b1, ONES);
    issue(OP_SMULH, MSB, MSB, 5'd6, 1'b1, 64'h4000_0000_0000_0000);
    issue(OP_UMULH, MSB, 64'd2, 5'd7, 1'b1, 64'd1);
    issue(OP_SMULH, 64'd2, 64'hFFFF_FFFF_FFFF_FFFD, 5'd8, 1'b1, ONES);
    issue(OP_MUL, 64'd0, 64'd5, 5'd9, 1'b1, 64'd0);
    drain();

    // XZR destination plus an ignored start while busy.
    d0 = done_cnt;
    issue(OP_MUL, 64'd7, 64'd9, 5'd31, 1'b1, 64'd63);
    repeat (10) @(negedge clk);
    bus.start = 1'b1;
    bus.op    = OP_MUL;
    bus.a     = 64'd11;
    bus.b     = 64'd13;
    bus.dest  = 5'd12;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (58) @(negedge clk);
    chk("one_done_in_70", N'(done_cnt - d0), N'(1));
    drain();

    // Flush mid-operation, with a simultaneous start that must be dropped.
    d0 = done_cnt;
    issue(OP_MUL, 64'd5, 64'd5, 5'd10, 1'b0, '0);
    repeat (19) @(negedge clk);
    bus.flush = 1'b1;
    bus.start = 1'b1;
    bus.a     = 64'd9;
    bus.b     = 64'd9;
    @(posedge clk);
    #1;
    bus.flush = 1'b0;
    bus.start = 1'b0;
    chk("flush_ready", N'(bus.ready), N'(1));
    chk("flush_done", N'(bus.done), N'(0));
    repeat (80) @(negedge clk);
    chk("flush_no_done", N'(done_cnt - d0), N'(0));
    issue(OP_MUL, 64'd4, 64'd4, 5'd11, 1'b1, 64'd16);
    drain();

    // Asynchronous reset in the middle of BUSY.
    repeat (2) @(negedge clk);
    d0 = done_cnt;
    issue(OP_UMULH, ONES, 64'd3, 5'd13, 1'b0, '0);
    repeat (40) @(negedge clk);
    #2;
    reset = 1'b0;
    #1;
    chk("async_rst_ready", N'(bus.ready), N'(1));
    chk("async_rst_we3", N'(bus.we3), N'(0));
    chk("async_rst_wd3", bus.wd3, '0);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    repeat (80) @(negedge clk);
    chk("rst_no_stale_done", N'(done_cnt - d0), N'(0));
    issue(OP_MUL, 64'd6, 64'd7, 5'd14, 1'b1, 64'd42);
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
